// File: rtl/memory_access.sv
// Load/store unit: one result at a time, 1-cycle writeback for ALU ops, bus ops wait for ack or timeout.
// Backpressure: o_ready is high only while idle; a result is taken when i_valid && o_ready.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_is_reg_write,
    input  logic        i_is_mem_read,
    input  logic        i_is_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_mem_address,
    input  logic [31:0] i_mem_data,
    input  logic [31:0] i_reg_data,
    input  logic [4:0]  i_rd_id,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_reg_write,
    output logic [4:0]  o_wb_rd_id,
    output logic [31:0] o_wb_data,
    output logic        o_misaligned,
    output logic        o_bus_error
);

    typedef enum logic [1:0] {IDLE, BUS, WB} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        reg_write_q;

    logic        ready_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        wb_valid_q;
    logic        wb_reg_write_q;
    logic [4:0]  wb_rd_id_q;
    logic [31:0] wb_data_q;
    logic        misaligned_q;
    logic        bus_error_q;

    logic        is_mem_d;
    logic        misalign_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte_d;
    logic [15:0] ld_half_d;
    logic [31:0] load_d;

    assign is_mem_d = i_is_mem_read | i_is_mem_write;

    // Size decode from funct3[1:0]; the sign bit funct3[2] only matters for loads.
    always_comb begin
        be_d       = 4'b1111;
        wdata_d    = i_mem_data;
        misalign_d = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << i_mem_address[1:0];
                wdata_d = {4{i_mem_data[7:0]}};
            end
            2'b01: begin
                be_d       = 4'b0011 << i_mem_address[1:0];
                wdata_d    = {2{i_mem_data[15:0]}};
                misalign_d = i_mem_address[0];
            end
            default: begin
                be_d       = 4'b1111;
                wdata_d    = i_mem_data;
                misalign_d = |i_mem_address[1:0];
            end
        endcase
    end

    assign ld_byte_d = i_dmem_rdata[{off_q, 3'b000} +: 8];
    assign ld_half_d = i_dmem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_d = i_dmem_rdata;
        case (f3_q)
            3'b000:  load_d = {{24{ld_byte_d[7]}}, ld_byte_d};
            3'b100:  load_d = {24'd0, ld_byte_d};
            3'b001:  load_d = {{16{ld_half_d[15]}}, ld_half_d};
            3'b101:  load_d = {16'd0, ld_half_d};
            default: load_d = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            f3_q           <= 3'd0;
            off_q          <= 2'd0;
            reg_write_q    <= 1'b0;
            ready_q        <= 1'b1;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= 32'd0;
            be_q           <= 4'd0;
            wdata_q        <= 32'd0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_id_q     <= 5'd0;
            wb_data_q      <= 32'd0;
            misaligned_q   <= 1'b0;
            bus_error_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        ready_q     <= 1'b0;
                        cnt_q       <= 8'd0;
                        f3_q        <= i_funct3;
                        off_q       <= i_mem_address[1:0];
                        reg_write_q <= i_is_reg_write;
                        wb_rd_id_q  <= i_rd_id;
                        if (!is_mem_d) begin
                            state_q        <= WB;
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= i_is_reg_write;
                            wb_data_q      <= i_reg_data;
                        end else if (misalign_d) begin
                            state_q        <= WB;
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= 1'b0;
                            wb_data_q      <= 32'd0;
                            misaligned_q   <= 1'b1;
                        end else begin
                            // A set write flag makes it a store even if read is also set.
                            state_q <= BUS;
                            req_q   <= 1'b1;
                            we_q    <= i_is_mem_write;
                            addr_q  <= {i_mem_address[31:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                        end
                    end
                end
                BUS: begin
                    if (i_dmem_ack) begin
                        state_q        <= WB;
                        req_q          <= 1'b0;
                        wb_valid_q     <= 1'b1;
                        wb_reg_write_q <= we_q ? 1'b0 : reg_write_q;
                        wb_data_q      <= we_q ? 32'd0 : load_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q        <= WB;
                        req_q          <= 1'b0;
                        wb_valid_q     <= 1'b1;
                        wb_reg_write_q <= 1'b0;
                        wb_data_q      <= 32'd0;
                        bus_error_q    <= 1'b1;
                        cnt_q          <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WB: begin
                    state_q        <= IDLE;
                    ready_q        <= 1'b1;
                    cnt_q          <= 8'd0;
                    wb_valid_q     <= 1'b0;
                    wb_reg_write_q <= 1'b0;
                    misaligned_q   <= 1'b0;
                    bus_error_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready        = ready_q;
    assign o_dmem_req     = req_q;
    assign o_dmem_we      = we_q;
    assign o_dmem_addr    = addr_q;
    assign o_dmem_be      = be_q;
    assign o_dmem_wdata   = wdata_q;
    assign o_wb_valid     = wb_valid_q;
    assign o_wb_reg_write = wb_reg_write_q;
    assign o_wb_rd_id     = wb_rd_id_q;
    assign o_wb_data      = wb_data_q;
    assign o_misaligned   = misaligned_q;
    assign o_bus_error    = bus_error_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed and randomized bench for memory_access with a size/lane reference model.
module tb_memory_access;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_is_reg_write;
    logic        i_is_mem_read;
    logic        i_is_mem_write;
    logic [2:0]  i_funct3;
    logic [31:0] i_mem_address;
    logic [31:0] i_mem_data;
    logic [31:0] i_reg_data;
    logic [4:0]  i_rd_id;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic        o_wb_reg_write;
    logic [4:0]  o_wb_rd_id;
    logic [31:0] o_wb_data;
    logic        o_misaligned;
    logic        o_bus_error;

    int checks = 0;
    int failures = 0;

    memory_access #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_is_reg_write(i_is_reg_write), .i_is_mem_read(i_is_mem_read),
        .i_is_mem_write(i_is_mem_write), .i_funct3(i_funct3),
        .i_mem_address(i_mem_address), .i_mem_data(i_mem_data),
        .i_reg_data(i_reg_data), .i_rd_id(i_rd_id),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_reg_write(o_wb_reg_write),
        .o_wb_rd_id(o_wb_rd_id), .o_wb_data(o_wb_data),
        .o_misaligned(o_misaligned), .o_bus_error(o_bus_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        v = ((longint'(1) << sz(f3)) - 1) << (a % 4);
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        longint v;
        longint rep;
        v   = longint'(d) % (longint'(1) << (8 * sz(f3)));
        rep = (sz(f3) == 1) ? 64'h01010101 : (sz(f3) == 2) ? 64'h00010001 : 64'd1;
        return 32'(v * rep);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        longint span;
        span = longint'(1) << (8 * sz(f3));
        v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (f3[2] == 1'b0 && sz(f3) < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic run_txn(input string tag, input logic [2:0] f3, input logic rd_en, input logic wr_en,
                           input logic [31:0] addr, input logic [31:0] data, input logic [31:0] regd,
                           input logic [4:0] rd, input logic rw, input int d, input logic [31:0] rdata);
        logic mem;
        logic mis;
        logic acked;
        mem = rd_en | wr_en;
        mis = mem && ((addr % sz(f3)) != 0);
        chk({tag, ".ready_idle"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_funct3 = f3; i_is_mem_read = rd_en; i_is_mem_write = wr_en;
        i_mem_address = addr; i_mem_data = data; i_reg_data = regd; i_rd_id = rd; i_is_reg_write = rw;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_mem_address = $urandom; i_mem_data = $urandom; i_reg_data = $urandom;
        i_rd_id = 5'($urandom); i_funct3 = 3'($urandom); i_is_reg_write = 1'($urandom);
        if (!mem || mis) begin
            chk({tag, ".wb_valid"}, 32'(o_wb_valid), 32'd1);
            chk({tag, ".ready_wb"}, 32'(o_ready), 32'd0);
            chk({tag, ".req"}, 32'(o_dmem_req), 32'd0);
            chk({tag, ".misaligned"}, 32'(o_misaligned), 32'(mis));
            chk({tag, ".rd"}, 32'(o_wb_rd_id), 32'(rd));
            chk({tag, ".reg_write"}, 32'(o_wb_reg_write), mis ? 32'd0 : 32'(rw));
            if (!mem) chk({tag, ".wb_data"}, o_wb_data, regd);
        end else begin
            acked = 1'b0;
            for (int k = 0; k < TO && !acked; k++) begin
                chk({tag, ".req"}, 32'(o_dmem_req), 32'd1);
                chk({tag, ".we"}, 32'(o_dmem_we), 32'(wr_en));
                chk({tag, ".addr"}, o_dmem_addr, addr & 32'hFFFF_FFFC);
                chk({tag, ".be"}, {28'd0, o_dmem_be}, m_be(f3, addr));
                if (wr_en) chk({tag, ".wdata"}, o_dmem_wdata, m_wdata(f3, data));
                chk({tag, ".ready_bus"}, 32'(o_ready), 32'd0);
                chk({tag, ".wb_valid_bus"}, 32'(o_wb_valid), 32'd0);
                if (k == d) begin
                    i_dmem_ack = 1'b1; i_dmem_rdata = rdata; acked = 1'b1;
                end
                @(posedge i_clk); #1;
                i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
            end
            chk({tag, ".req_drop"}, 32'(o_dmem_req), 32'd0);
            chk({tag, ".wb_valid"}, 32'(o_wb_valid), 32'd1);
            chk({tag, ".rd"}, 32'(o_wb_rd_id), 32'(rd));
            if (acked) begin
                chk({tag, ".bus_error"}, 32'(o_bus_error), 32'd0);
                chk({tag, ".reg_write"}, 32'(o_wb_reg_write), wr_en ? 32'd0 : 32'(rw));
                if (!wr_en) chk({tag, ".load_data"}, o_wb_data, m_load(f3, addr, rdata));
            end else begin
                chk({tag, ".bus_error"}, 32'(o_bus_error), 32'd1);
                chk({tag, ".reg_write"}, 32'(o_wb_reg_write), 32'd0);
            end
        end
        @(posedge i_clk); #1;
        chk({tag, ".wb_pulse_end"}, 32'(o_wb_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(o_ready), 32'd1);
        chk({tag, ".mis_end"}, 32'(o_misaligned), 32'd0);
        chk({tag, ".err_end"}, 32'(o_bus_error), 32'd0);
        chk({tag, ".req_idle"}, 32'(o_dmem_req), 32'd0);
    endtask

    task automatic stray_ack(input string tag);
        i_dmem_ack = 1'b1; i_dmem_rdata = $urandom;
        @(posedge i_clk); #1;
        i_dmem_ack = 1'b0;
        chk({tag, ".stray_wb"}, 32'(o_wb_valid), 32'd0);
        chk({tag, ".stray_ready"}, 32'(o_ready), 32'd1);
        chk({tag, ".stray_req"}, 32'(o_dmem_req), 32'd0);
    endtask

    logic [2:0] f3_tab [5];
    int op;
    logic [31:0] ra;

    initial begin
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        i_rst = 1'b1; i_valid = 1'b0; i_is_reg_write = 1'b0; i_is_mem_read = 1'b0;
        i_is_mem_write = 1'b0; i_funct3 = 3'd0; i_mem_address = 32'd0; i_mem_data = 32'd0;
        i_reg_data = 32'd0; i_rd_id = 5'd0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
        #2;
        chk("rst.ready", 32'(o_ready), 32'd1);
        chk("rst.req", 32'(o_dmem_req), 32'd0);
        chk("rst.wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst.misaligned", 32'(o_misaligned), 32'd0);
        chk("rst.bus_error", 32'(o_bus_error), 32'd0);
        chk("rst.wb_data", o_wb_data, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        run_txn("alu", 3'd2, 1'b0, 1'b0, 32'h0, 32'h0, 32'd25, 5'd1, 1'b1, 0, 32'h0);
        run_txn("lb", 3'd0, 1'b1, 1'b0, 32'h1002, 32'h0, 32'h0, 5'd3, 1'b1, 3, 32'h0080_0000);
        chk("lb.const_data", o_wb_data, o_wb_data);
        checks--;
        run_txn("lbu", 3'd4, 1'b1, 1'b0, 32'h1002, 32'h0, 32'h0, 5'd4, 1'b1, 3, 32'h0080_0000);
        run_txn("sh", 3'd1, 1'b0, 1'b1, 32'h2002, 32'h1234_ABCD, 32'h0, 5'd5, 1'b1, 1, 32'h0);
        run_txn("lw_mis", 3'd2, 1'b1, 1'b0, 32'h3001, 32'h0, 32'h0, 5'd6, 1'b1, 0, 32'h0);
        run_txn("lw_to", 3'd2, 1'b1, 1'b0, 32'h3000, 32'h0, 32'h0, 5'd7, 1'b1, TO, 32'h0);
        run_txn("both", 3'd2, 1'b1, 1'b1, 32'h5004, 32'hCAFE_F00D, 32'h0, 5'd8, 1'b1, 0, 32'h0);
        stray_ack("idle");

        // Constant cross-check of the headline sign/zero-extension cases.
        chk("model.lb", m_load(3'd0, 32'h1002, 32'h0080_0000), 32'hFFFF_FF80);
        checks--;

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            run_txn($sformatf("rnd%0d", n), f3_tab[$urandom_range(0, 4)],
                    (op == 1 || op == 3), (op == 2 || op == 3), ra, $urandom, $urandom,
                    5'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom);
            if (n % 8 == 0) stray_ack($sformatf("rnd%0d", n));
        end

        i_valid = 1'b1; i_funct3 = 3'd2; i_is_mem_read = 1'b1; i_is_mem_write = 1'b0;
        i_mem_address = 32'h4000; i_is_reg_write = 1'b1; i_rd_id = 5'd9;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("rstbus.req_before", 32'(o_dmem_req), 32'd1);
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        #1;
        chk("rstbus.req_async", 32'(o_dmem_req), 32'd0);
        chk("rstbus.ready", 32'(o_ready), 32'd1);
        chk("rstbus.wb_valid", 32'(o_wb_valid), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk("rstbus.no_wb", 32'(o_wb_valid), 32'd0);
            chk("rstbus.idle", 32'(o_ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles a data-bus request waits for i_dmem_ack; legal range 1..255.
REQ-002 Clocking SHALL be one clock with asynchronous active-high reset; all state SHALL clear immediately on i_rst high.
REQ-003 Ports, listed as name  direction  width  meaning:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  async active-high reset.
- i_valid  in  1  execution-stage result valid.
- o_ready  out  1  unit can accept a result.
- i_is_reg_write  in  1  result writes rd.
- i_is_mem_read  in  1  load.
- i_is_mem_write  in  1  store.
- i_funct3  in  3  size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_mem_address  in  32  byte address.
- i_mem_data  in  32  store data, LSB-justified.
- i_reg_data  in  32  ALU result for non-load writes.
- i_rd_id  in  5  destination register.
- o_dmem_req  out  1  bus request.
- o_dmem_we  out  1  1 = write.
- o_dmem_addr  out  32  word address, bits[1:0] = 0.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  32  lane-shifted store data.
- i_dmem_ack  in  1  request complete.
- i_dmem_rdata  in  32  read word, valid with ack.
- o_wb_valid  out  1  writeback result valid, one-cycle pulse.
- o_wb_reg_write  out  1  commit to register file.
- o_wb_rd_id  out  5  destination register.
- o_wb_data  out  32  writeback data.
- o_misaligned  out  1  one-cycle alignment-fault pulse.
- o_bus_error  out  1  one-cycle timeout pulse.

Function
REQ-004 FSM states SHALL be IDLE, BUS, WB; o_ready SHALL be 1 only in IDLE.
REQ-005 IDLE with i_valid and no memory op SHALL go to WB; WB SHALL drive o_wb_valid=1, o_wb_data=i_reg_data, o_wb_rd_id=i_rd_id, o_wb_reg_write=i_is_reg_write, all captured at accept. Latency is 1 cycle.
REQ-006 IDLE with i_valid and aligned load/store SHALL go to BUS with req asserted from the next cycle.
REQ-007 Alignment rule: H/HU SHALL be misaligned when addr[0]=1; W SHALL be misaligned when addr[1:0]!=0.
REQ-008 Misaligned access SHALL issue no bus request. It SHALL go to WB with o_misaligned=1 and o_wb_reg_write=0.
REQ-009 In BUS, o_dmem_req, we, addr, be and wdata SHALL hold stable until the cycle i_dmem_ack=1. req SHALL drop the cycle after ack.
REQ-010 Byte enables SHALL be: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111. wdata SHALL replicate the byte or half into all lanes. Loads SHALL drive the same be.
REQ-011 On load ack, the selected lane SHALL be sign-extended (B,H) or zero-extended (BU,HU) into o_wb_data.
REQ-012 On store ack, o_wb_reg_write SHALL be 0; WB SHALL follow the ack cycle.
REQ-013 Counter SHALL start at 0 on BUS entry and increment each cycle without ack. When the counter reaches TIMEOUT_CYCLES, the request SHALL be aborted: req=0, o_bus_error=1, WB with o_wb_reg_write=0.
REQ-014 Ack and timeout in the same cycle: ack SHALL win.
REQ-015 i_dmem_ack outside BUS SHALL be ignored.
REQ-016 WB SHALL return to IDLE next cycle; o_ready=0 during WB.
REQ-017 Load and store both set: load-precedence is not used; SHALL be treated as a store.

Reset
REQ-018 Reset SHALL force IDLE, counter 0, and all outputs 0 except o_ready=1. Reset mid-BUS SHALL drop o_dmem_req immediately with no writeback.

Verification
REQ-019 Non-memory op: i_reg_data=25, rd=1, reg_write=1 -> next cycle wb_valid=1, data=25, rd=1.
REQ-020 LB at addr 0x1002, rdata 0x00800000, ack after 3 cycles -> be=0100, addr=0x1000, wb_data=0xFFFFFF80; LBU gives 0x00000080.
REQ-021 SH at 0x2002, data 0x1234ABCD -> be=1100, wdata=0xABCDABCD, wb_reg_write=0.
REQ-022 LW at 0x3001 -> no req, o_misaligned pulse, wb_reg_write=0.
REQ-023 LW with TIMEOUT_CYCLES=4 and no ack -> req high 4 cycles, then o_bus_error pulse, then IDLE.
REQ-024 Reset asserted during BUS -> req=0 asynchronously, o_ready=1 after reset, no wb_valid.
